// File: rtl/ysyx_22050039_imem_resp.sv
// Instruction-memory responder: one fetch outstanding at a time, fixed LATENCY from
// accept to response, with a side write port to preload the program image.
module ysyx_22050039_imem_resp #(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter int              DEPTH    = 4096,
  parameter logic [XLEN-1:0] BASE     = XLEN'(64'h8000_0000),
  parameter int              LATENCY  = 2,
  localparam int             IDX_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [XLEN-1:0]     req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [INST_LEN-1:0] resp_inst,
  output logic                resp_err,
  input  logic                ld_en,
  input  logic [IDX_W-1:0]    ld_idx,
  input  logic [INST_LEN-1:0] ld_data
);

  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               err_reg;
  logic [INST_LEN-1:0] rd_data_reg;

  logic [INST_LEN-1:0] mem [DEPTH];

  logic               accept;
  logic [XLEN-1:0]    off;
  logic [XLEN-1:0]    word_off;
  logic [IDX_W-1:0]   req_idx;
  logic               req_err;

  assign accept = (state_reg == S_IDLE) && req_valid;

  // Address decode; the offset is unsigned, so a pc below BASE wraps to a huge value.
  always_comb begin
    off      = req_addr - BASE;
    word_off = off >> 2;
    req_idx  = word_off[IDX_W-1:0];
    req_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (word_off >= XLEN'(DEPTH));
  end

  // Both ports share one edge; the non-blocking read returns the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
    if (accept && !rst) begin
      rd_data_reg <= mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        err_reg <= req_err;
      end
    end
  end

  // WAIT lasts LATENCY-1 cycles: the decrement that reaches zero coincides with entering RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (DIRECT) begin
            state_next = S_RESP;
            cnt_next   = '0;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = S_RESP;
          cnt_next   = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == S_IDLE);
    resp_valid = (state_reg == S_RESP);
    resp_err   = resp_valid && err_reg;
    resp_inst  = (resp_valid && !err_reg) ? rd_data_reg : '0;
  end

endmodule
